// File: rtl/entrada_saida_ctrl.sv
// entrada_saida_ctrl: I/O handshake controller between the core and the board
// switches, enter push-button and display. Each IN or OUT request stalls the
// core until the user confirms with a clean (debounced) press of enter.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   entrada         switch bank value, captured when an IN is confirmed
//   in, out         core request levels (in has priority)
//   dado_saida      value to display, latched when an OUT is accepted
//   enter           raw asynchronous push-button, active-high
//   sinal           stall to the core while an operation awaits confirmation
//   valor           last confirmed switch value
//   display         value latched by the last OUT request
//   display_valid   set once any OUT has been accepted since reset
//   pronto          one-cycle pulse per confirmed operation
module entrada_saida_ctrl #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada,
    input  logic             in,
    input  logic             out,
    input  logic [WIDTH-1:0] dado_saida,
    input  logic             enter,
    output logic             sinal,
    output logic [WIDTH-1:0] valor,
    output logic [WIDTH-1:0] display,
    output logic             display_valid,
    output logic             pronto
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IN  = 2'd1,
        WAIT_OUT = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   enter_s;
    logic                   enter_db;
    logic                   enter_db_q;
    logic [CNT_W-1:0]       cnt;
    logic                   confirm_c;

    assign enter_s   = sync[SYNC_STAGES-1];
    assign confirm_c = enter_db & ~enter_db_q;

    // Synchroniser chain for the raw button
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], enter};
        end
    end

    // Debouncer: the level toggles only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; the toggle happens on the edge of the last one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            enter_db   <= 1'b0;
            enter_db_q <= 1'b0;
        end else begin
            enter_db_q <= enter_db;
            if (enter_s != enter_db) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    enter_db <= enter_s;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Handshake FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sinal         <= 1'b0;
            valor         <= '0;
            display       <= '0;
            display_valid <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (state)
                IDLE: begin
                    // A button still held from a previous press blocks new requests
                    if (!enter_db) begin
                        if (in) begin
                            sinal <= 1'b1;
                            state <= WAIT_IN;
                        end else if (out) begin
                            display       <= dado_saida;
                            display_valid <= 1'b1;
                            sinal         <= 1'b1;
                            state         <= WAIT_OUT;
                        end
                    end
                end
                WAIT_IN: begin
                    if (confirm_c) begin
                        valor  <= entrada;
                        sinal  <= 1'b0;
                        pronto <= 1'b1;
                        state  <= RELEASE;
                    end
                end
                WAIT_OUT: begin
                    if (confirm_c) begin
                        sinal  <= 1'b0;
                        pronto <= 1'b1;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the button to be released before serving again
                    if (!enter_db) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entrada_saida_ctrl.sv
// Testbench for entrada_saida_ctrl: table of timed steps plus hand-written
// sequences for debounce glitches, held enter, and asynchronous reset.
module tb_entrada_saida_ctrl;

    localparam int unsigned WIDTH = 18;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] entrada;
    logic             req_in;
    logic             req_out;
    logic [WIDTH-1:0] dado_saida;
    logic             enter;
    logic             sinal;
    logic [WIDTH-1:0] valor;
    logic [WIDTH-1:0] display;
    logic             display_valid;
    logic             pronto;

    int tests;
    int errors;
    int sinal_cnt;
    int pronto_cnt;
    int p0;

    entrada_saida_ctrl #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .entrada(entrada),
        .in(req_in),
        .out(req_out),
        .dado_saida(dado_saida),
        .enter(enter),
        .sinal(sinal),
        .valor(valor),
        .display(display),
        .display_valid(display_valid),
        .pronto(pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned      n;
        logic             i;
        logic             o;
        logic             e;
        logic [WIDTH-1:0] ent;
        logic [WIDTH-1:0] dado;
        logic             s;
        logic             p;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] d;
        logic             dv;
    } step_t;

    step_t steps[$];

    task automatic add(input int unsigned n, input logic i, input logic o, input logic e,
                       input logic [WIDTH-1:0] ent, input logic [WIDTH-1:0] dado,
                       input logic s, input logic p, input logic [WIDTH-1:0] v,
                       input logic [WIDTH-1:0] d, input logic dv);
        step_t st;
        st = '{n, i, o, e, ent, dado, s, p, v, d, dv};
        steps.push_back(st);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it
    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (sinal) sinal_cnt++;
            if (pronto) pronto_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; errors = 0; sinal_cnt = 0; pronto_cnt = 0;
        reset = 1'b1; entrada = '0; req_in = 1'b0; req_out = 1'b0;
        dado_saida = '0; enter = 1'b0;

        // IN: request, 10 edges later press; confirm 6 edges after the press
        add(1, 1,0,0, 18'h00000, 18'h00000, 1,0, 18'h00000, 18'h00000, 0);
        add(9, 1,0,0, 18'h2A5C3, 18'h00000, 1,0, 18'h00000, 18'h00000, 0);
        add(1, 1,0,1, 18'h2A5C3, 18'h00000, 1,0, 18'h00000, 18'h00000, 0);
        add(5, 1,0,1, 18'h2A5C3, 18'h00000, 1,0, 18'h00000, 18'h00000, 0);
        add(1, 1,0,1, 18'h2A5C3, 18'h00000, 0,1, 18'h2A5C3, 18'h00000, 0);
        add(1, 0,0,1, 18'h2A5C3, 18'h00000, 0,0, 18'h2A5C3, 18'h00000, 0);
        add(7, 0,0,0, 18'h00000, 18'h00000, 0,0, 18'h2A5C3, 18'h00000, 0);
        // OUT: display latched at acceptance, later dado_saida changes ignored
        add(1, 0,1,0, 18'h00000, 18'h00FF0, 1,0, 18'h2A5C3, 18'h00FF0, 1);
        add(3, 0,1,0, 18'h00000, 18'h00000, 1,0, 18'h2A5C3, 18'h00FF0, 1);
        add(6, 0,0,1, 18'h00000, 18'h00000, 1,0, 18'h2A5C3, 18'h00FF0, 1);
        add(1, 0,0,1, 18'h00000, 18'h00000, 0,1, 18'h2A5C3, 18'h00FF0, 1);
        add(7, 0,0,0, 18'h00000, 18'h00000, 0,0, 18'h2A5C3, 18'h00FF0, 1);
        // Back-to-back IN with in held high
        add(1, 1,0,0, 18'h00001, 18'h00000, 1,0, 18'h2A5C3, 18'h00FF0, 1);
        add(6, 1,0,1, 18'h00001, 18'h00000, 1,0, 18'h2A5C3, 18'h00FF0, 1);
        add(1, 1,0,1, 18'h00001, 18'h00000, 0,1, 18'h00001, 18'h00FF0, 1);
        add(1, 1,0,0, 18'h3FFFF, 18'h00000, 0,0, 18'h00001, 18'h00FF0, 1);
        add(5, 1,0,0, 18'h3FFFF, 18'h00000, 0,0, 18'h00001, 18'h00FF0, 1);
        add(1, 1,0,0, 18'h3FFFF, 18'h00000, 0,0, 18'h00001, 18'h00FF0, 1);
        add(1, 1,0,0, 18'h3FFFF, 18'h00000, 1,0, 18'h00001, 18'h00FF0, 1);
        add(6, 1,0,1, 18'h3FFFF, 18'h00000, 1,0, 18'h00001, 18'h00FF0, 1);
        add(1, 1,0,1, 18'h3FFFF, 18'h00000, 0,1, 18'h3FFFF, 18'h00FF0, 1);
        add(7, 0,0,0, 18'h3FFFF, 18'h00000, 0,0, 18'h3FFFF, 18'h00FF0, 1);

        // Reset state
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_sinal", 32'(sinal), 32'd0);
        chk("rst_valor", 32'(valor), 32'd0);
        chk("rst_display", 32'(display), 32'd0);
        chk("rst_dv", 32'(display_valid), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        reset = 1'b0;

        foreach (steps[idx]) begin
            req_in     = steps[idx].i;
            req_out    = steps[idx].o;
            enter      = steps[idx].e;
            entrada    = steps[idx].ent;
            dado_saida = steps[idx].dado;
            tick(steps[idx].n);
            chk($sformatf("step%0d_sinal", idx), 32'(sinal), 32'(steps[idx].s));
            chk($sformatf("step%0d_pronto", idx), 32'(pronto), 32'(steps[idx].p));
            chk($sformatf("step%0d_valor", idx), 32'(valor), 32'(steps[idx].v));
            chk($sformatf("step%0d_display", idx), 32'(display), 32'(steps[idx].d));
            chk($sformatf("step%0d_dv", idx), 32'(display_valid), 32'(steps[idx].dv));
            if (idx == 6) chk("in_stall_cycles", 32'(sinal_cnt), 32'd16);
        end
        chk("table_pronto_pulses", 32'(pronto_cnt), 32'd4);
        chk("table_stall_cycles", 32'(sinal_cnt), 32'd40);

        // Debounce: a 3-sample glitch never confirms, a 5-sample press confirms once
        p0 = pronto_cnt;
        req_in = 1'b1; entrada = 18'h12345;
        tick(1);
        chk("glitch_accept", 32'(sinal), 32'd1);
        enter = 1'b1; tick(3);
        enter = 1'b0; tick(10);
        chk("glitch_sinal", 32'(sinal), 32'd1);
        chk("glitch_no_pronto", 32'(pronto_cnt), 32'(p0));
        enter = 1'b1; tick(5);
        enter = 1'b0; tick(1);
        chk("press5_wait", 32'(sinal), 32'd1);
        tick(1);
        chk("press5_sinal", 32'(sinal), 32'd0);
        chk("press5_pronto", 32'(pronto), 32'd1);
        chk("press5_valor", 32'(valor), 32'h12345);
        req_in = 1'b0; tick(8);
        chk("press5_one_pulse", 32'(pronto_cnt), 32'(p0 + 1));

        // Held enter blocks requests; after release the IN wins over OUT
        enter = 1'b1; tick(7);
        req_in = 1'b1; req_out = 1'b1; dado_saida = 18'h11111; entrada = 18'h0ABCD;
        tick(3);
        chk("held_no_accept", 32'(sinal), 32'd0);
        chk("held_display", 32'(display), 32'h00FF0);
        enter = 1'b0; tick(6);
        chk("release_not_yet", 32'(sinal), 32'd0);
        tick(1);
        chk("release_accept", 32'(sinal), 32'd1);
        chk("prio_display", 32'(display), 32'h00FF0);
        req_in = 1'b0; req_out = 1'b0;
        enter = 1'b1; tick(6);
        chk("prio_wait", 32'(sinal), 32'd1);
        tick(1);
        chk("prio_pronto", 32'(pronto), 32'd1);
        chk("prio_valor", 32'(valor), 32'h0ABCD);
        chk("prio_display2", 32'(display), 32'h00FF0);
        enter = 1'b0; tick(8);

        // Asynchronous reset mid WAIT_OUT
        p0 = pronto_cnt;
        req_out = 1'b1; dado_saida = 18'h15555;
        tick(1);
        chk("arst_accept", 32'(sinal), 32'd1);
        chk("arst_disp_pre", 32'(display), 32'h15555);
        req_out = 1'b0; tick(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_sinal", 32'(sinal), 32'd0);
        chk("arst_display", 32'(display), 32'd0);
        chk("arst_dv", 32'(display_valid), 32'd0);
        chk("arst_valor", 32'(valor), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        req_in = 1'b1; entrada = 18'h2AAAA;
        tick(1);
        chk("post_rst_accept", 32'(sinal), 32'd1);
        enter = 1'b1; tick(6);
        chk("post_rst_wait", 32'(sinal), 32'd1);
        tick(1);
        chk("post_rst_sinal", 32'(sinal), 32'd0);
        chk("post_rst_valor", 32'(valor), 32'h2AAAA);
        req_in = 1'b0; enter = 1'b0; tick(8);
        chk("post_rst_pulses", 32'(pronto_cnt), 32'(p0 + 1));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/entrada_saida_ctrl.md
# entrada_saida_ctrl

Parametrised I/O handshake controller between the processor core and the board switches, push-button and display. It serves both IN requests (read a WIDTH-bit value from the switches) and OUT requests (present a WIDTH-bit value on the display). For each request it stalls the core until the user confirms with the enter button. The enter button is synchronised and debounced internally. Input data is captured at confirmation time, not at request time.

## Interface
Parameters:
- WIDTH, 18: data width of switches, input value and display value.
- SYNC_STAGES, 2: synchroniser depth on the raw enter button (≥2).
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to change the debounced enter level (≥1).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- entrada  in  WIDTH  switch bank value.
- in  in  1  core requests an IN operation (level).
- out  in  1  core requests an OUT operation (level).
- dado_saida  in  WIDTH  value the core wants displayed.
- enter  in  1  raw, asynchronous push-button, active-high.
- sinal  out  1  stall to core: high while an operation awaits confirmation.
- valor  out  WIDTH  last confirmed switch value.
- display  out  WIDTH  value latched by the last OUT request.
- display_valid  out  1  high once any OUT has been requested since reset.
- pronto  out  1  one-cycle pulse when an operation is confirmed.

## Operation
- Enter conditioning:
  - enter passes through a SYNC_STAGES flop chain to give enter_s.
  - A counter counts consecutive edges on which enter_s differs from enter_db. It clears on any edge where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, enter_db toggles and the counter clears.
  - confirm = enter_db rising edge: enter_db is 1 this cycle and its registered copy is 0.
- IDLE state:
  - If enter_db=0 and in=1: capture nothing, set sinal=1, go to WAIT_IN.
  - Else if enter_db=0 and out=1: set display<=dado_saida and display_valid<=1, set sinal=1, go to WAIT_OUT.
  - in has priority when in and out are both high.
  - Requests are ignored while enter_db=1.
- WAIT_IN: on confirm, set valor<=entrada, sinal<=0, pronto<=1, go to RELEASE.
- WAIT_OUT: on confirm, set sinal<=0, pronto<=1, go to RELEASE. display is held unchanged.
- RELEASE: sinal=0. Return to IDLE when enter_db=0. If in/out is still high at that point, a new request is accepted on the next IDLE cycle.
- in/out changing while in a WAIT state has no effect. The operation type is fixed at acceptance.
- display and display_valid change only on OUT acceptance. valor changes only on IN confirmation.

## Timing
- Reset, asynchronous: state=IDLE, sinal=0, valor=0, display=0, display_valid=0, pronto=0, sync chain=0, enter_db=0, counter=0.
- Request sampled in IDLE at edge N: sinal is high from edge N, so it is visible in cycle N+1. For OUT, display is updated at the same edge.
- Raw enter rises and stays high from sample edge k: enter_db rises at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Confirm is acted on at the next edge: sinal falls, valor/pronto update. This is SYNC_STAGES+DEBOUNCE_CYCLES cycles after k (6 with defaults).
- pronto is high for exactly one cycle per confirmed operation.
- An enter pulse or glitch shorter than DEBOUNCE_CYCLES synchronised samples does not toggle enter_db and never confirms.
- Enter held from before a request: no confirm until enter_db has fallen and risen again.
- Reset asserted mid-WAIT: operation is abandoned, all outputs go to reset values immediately, no pronto.
- Minimum request-to-request spacing: confirm, then enter_db fall (≥DEBOUNCE_CYCLES cycles after release), then 1 IDLE cycle.

## Test plan
- Reset then IN: in=1 at edge 10, sinal=1 from cycle 11. Set entrada=18'h2A5C3, then press enter at edge 20. Expect valor=18'h2A5C3, sinal=0, pronto=1 at edge 26, and sinal=1 for 16 cycles total.
- OUT: dado_saida=18'h00FF0, out=1. Expect display=18'h00FF0 and display_valid=1 with sinal=1 one edge later. Change dado_saida to 0 while waiting: display stays 18'h00FF0. Enter confirms: pronto pulse, display unchanged.
- Debounce: 3-cycle enter pulse during WAIT_IN causes no confirm and sinal stays 1. A following 5-cycle pulse confirms once, with exactly one pronto.
- Held enter / simultaneous requests: enter held high while in=1 and out=1 asserted, so no request is accepted. Release enter: after debounce, the IN is accepted (priority) and display is unchanged. Next clean press confirms IN.
- Back-to-back: in held high across two presses gives two IN operations and two pronto pulses. valor takes the entrada value present at each confirm (18'h00001, then 18'h3FFFF).
- Async reset asserted mid-WAIT_OUT, between clock edges: sinal, display and display_valid go to 0 immediately. After deassertion, state is IDLE and a new request works normally.
